fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_if.sv | 54 +++++
 rtl/fifo_stream_reader.sv | 152 +++++++++++++++
 tb/tb_fifo_stream_reader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader_if
//  Description : Bundles the show-ahead FIFO read port and the outgoing
//                valid/ready beat stream of fifo_stream_reader.
//                  fifo_rd_data_i  FIFO head word (valid while not empty)
//                  fifo_empty_i    FIFO empty flag
//                  fifo_rd_o       FIFO pop request
//                  m_data_o        stream beat data
//                  m_valid_o       stream beat valid
//                  m_ready_i       stream beat ready
//                  m_last_o        final beat of a FIFO word
//                  words_cnt_o     count of fully transmitted FIFO words
//                master : the reader side (drives pop and stream outputs)
//                slave  : the environment (FIFO and stream consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] fifo_rd_data_i;
    logic                  fifo_empty_i;
    logic                  fifo_rd_o;
    logic [OUT_WIDTH-1:0]  m_data_o;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic                  m_last_o;
    logic [CNT_WIDTH-1:0]  words_cnt_o;

    modport master (
        input  fifo_rd_data_i,
        input  fifo_empty_i,
        input  m_ready_i,
        output fifo_rd_o,
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        output words_cnt_o
    );

    modport slave (
        output fifo_rd_data_i,
        output fifo_empty_i,
        output m_ready_i,
        input  fifo_rd_o,
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        input  words_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Pops DATA_WIDTH words from a show-ahead FIFO and emits each
//                one as RATIO = DATA_WIDTH/OUT_WIDTH valid/ready beats, in
//                LSB-first or MSB-first slice order. A new word is popped on
//                the same edge the last beat of the previous one is accepted,
//                so a non-empty FIFO streams with no bubbles.
//  Ports       : clk_i  - rising-edge clock
//                rst_i  - asynchronous active-high reset
//                bus    - fifo_stream_reader_if.master (FIFO read port,
//                         beat stream and word counter)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int LSB_FIRST  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    fifo_stream_reader_if.master  bus
);

    localparam int                RATIO    = DATA_WIDTH / OUT_WIDTH;
    localparam int                IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  word_q,  word_d;
    logic [IDX_W-1:0]       idx_q,   idx_d;
    logic [IDX_W-1:0]       idx_inc;
    logic [OUT_WIDTH-1:0]   data_q,  data_d;
    logic                   valid_q, valid_d;
    logic                   last_q,  last_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic                   pop;
    logic                   beat_accept;

    // Returns the beat presented at position k of word w, honouring the
    // configured slice order.
    function automatic logic [OUT_WIDTH-1:0] slice_of(
        input logic [DATA_WIDTH-1:0] w,
        input logic [IDX_W-1:0]      k
    );
        int unsigned           pos;
        logic [DATA_WIDTH-1:0] shifted;
        if (LSB_FIRST != 0) begin
            pos = 32'(k);
        end else begin
            pos = 32'(RATIO - 1) - 32'(k);
        end
        shifted = w >> (pos * 32'(OUT_WIDTH));
        return shifted[OUT_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        idx_inc     = idx_q + IDX_W'(1);
        beat_accept = valid_q && bus.m_ready_i;

        // Pop when nothing is held, or when the beat leaving this cycle is
        // the last of the held word. Gated by reset so the FIFO is never
        // drained while the reader is held in reset.
        pop = !rst_i && !bus.fifo_empty_i &&
              ((state_q == ST_IDLE) || (bus.m_ready_i && last_q));

        if (beat_accept && last_q) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        if (pop) begin
            // Load takes priority: covers both the IDLE start and the
            // back-to-back reload on the final beat of the previous word.
            state_d = ST_SEND;
            word_d  = bus.fifo_rd_data_i;
            idx_d   = '0;
            data_d  = slice_of(bus.fifo_rd_data_i, '0);
            valid_d = 1'b1;
            last_d  = (RATIO == 1);
        end else if ((state_q == ST_SEND) && beat_accept) begin
            if (last_q) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                idx_d   = idx_inc;
                data_d  = slice_of(word_q, idx_inc);
                last_d  = (idx_inc == LAST_IDX);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fifo_rd_o   = pop;
    assign bus.m_data_o    = data_q;
    assign bus.m_valid_o   = valid_q;
    assign bus.m_last_o    = last_q;
    assign bus.words_cnt_o = cnt_q;

    // ------------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------------
    a_no_pop_when_empty : assert property (
        @(posedge clk_i) disable iff (rst_i)
        bus.fifo_empty_i |-> !bus.fifo_rd_o
    );

    a_hold_on_stall : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (valid_q && !bus.m_ready_i) |=> (valid_q && $stable(data_q) && $stable(last_q))
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Self-checking bench for fifo_stream_reader. Three
//                configurations run side by side:
//                  c0 : 32/8, LSB first, 16-bit counter
//                  c1 : 32/8, MSB first, 4-bit counter
//                  c2 : 8/8 (one beat per word), LSB first, 16-bit counter
//                Each has a queue-based FIFO and a beat-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar K = 0; K < 3; K++) begin : g_cfg
        localparam int DW  = (K == 2) ? 8 : 32;
        localparam int OW  = 8;
        localparam int LSB = (K == 1) ? 0 : 1;
        localparam int CW  = (K == 1) ? 4 : 16;
        localparam int R   = DW / OW;

        fifo_stream_reader_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

        fifo_stream_reader #(
            .DATA_WIDTH (DW),
            .OUT_WIDTH  (OW),
            .LSB_FIRST  (LSB),
            .CNT_WIDTH  (CW)
        ) dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );

        logic [31:0] fifo_q[$];     // external FIFO contents
        logic [7:0]  beats_q[$];    // beats of the held word still to be accepted
        logic [7:0]  exp_data;
        int          exp_cnt;
        int          pops;
        int          ready_pct = 100;
        logic [31:0] mon[6];

        assign mon[0] = 32'(bus.m_valid_o);
        assign mon[1] = 32'(bus.m_data_o);
        assign mon[2] = 32'(bus.m_last_o);
        assign mon[3] = 32'(bus.words_cnt_o);
        assign mon[4] = 32'(bus.fifo_rd_o);
        assign mon[5] = 32'(pops);

        function automatic void load_word(input logic [31:0] w);
            for (int i = 0; i < R; i++) begin
                int k;
                k = (LSB != 0) ? i : (R - 1 - i);
                beats_q.push_back(8'((w >> (8 * k)) & 32'hFF));
            end
        endfunction

        initial begin
            logic [31:0] hd;
            logic        v, lst, rdy, emp, exp_rd;
            string       pfx;
            pfx      = $sformatf("c%0d", K);
            exp_data = 8'h00;
            exp_cnt  = 0;
            pops     = 0;
            bus.m_ready_i      = 1'b0;
            bus.fifo_empty_i   = 1'b1;
            bus.fifo_rd_data_i = '0;
            forever begin
                @(negedge clk);
                v   = (beats_q.size() != 0);
                lst = (beats_q.size() == 1);
                emp = (fifo_q.size() == 0);
                hd  = emp ? $urandom() : fifo_q[0];
                if (rst) begin
                    beats_q.delete();
                    exp_data = 8'h00;
                    exp_cnt  = 0;
                    check_val({pfx, " rst valid"}, mon[0], 32'd0);
                    check_val({pfx, " rst data"},  mon[1], 32'd0);
                    check_val({pfx, " rst last"},  mon[2], 32'd0);
                    check_val({pfx, " rst cnt"},   mon[3], 32'd0);
                    bus.m_ready_i      = 1'($urandom_range(1));
                    bus.fifo_empty_i   = emp;
                    bus.fifo_rd_data_i = hd[DW-1:0];
                    #1;
                    check_val({pfx, " rst fifo_rd"}, mon[4], 32'd0);
                end else begin
                    check_val({pfx, " valid"}, mon[0], 32'(v));
                    check_val({pfx, " data"},  mon[1], 32'(exp_data));
                    check_val({pfx, " last"},  mon[2], 32'(lst));
                    check_val({pfx, " cnt"},   mon[3], 32'(exp_cnt) & ((32'd1 << CW) - 32'd1));
                    rdy = ($urandom_range(99) < ready_pct);
                    bus.m_ready_i      = rdy;
                    bus.fifo_empty_i   = emp;
                    bus.fifo_rd_data_i = hd[DW-1:0];
                    #1;
                    exp_rd = !emp && (!v || (rdy && lst));
                    check_val({pfx, " fifo_rd"}, mon[4], 32'(exp_rd));
                    // Effect of the coming rising edge
                    if (v && rdy) begin
                        void'(beats_q.pop_front());
                        if (beats_q.size() == 0) exp_cnt++;
                    end
                    if (exp_rd) begin
                        load_word(fifo_q.pop_front());
                        pops++;
                    end
                    if (beats_q.size() != 0) exp_data = beats_q[0];
                end
            end
        end
    end

    task automatic push(input int k, input logic [31:0] w);
        case (k)
            0:       g_cfg[0].fifo_q.push_back(w);
            1:       g_cfg[1].fifo_q.push_back(w);
            default: g_cfg[2].fifo_q.push_back(w);
        endcase
    endtask

    function automatic logic is_idle(input int k);
        case (k)
            0:       return (g_cfg[0].fifo_q.size() == 0) && (g_cfg[0].beats_q.size() == 0);
            1:       return (g_cfg[1].fifo_q.size() == 0) && (g_cfg[1].beats_q.size() == 0);
            default: return (g_cfg[2].fifo_q.size() == 0) && (g_cfg[2].beats_q.size() == 0);
        endcase
    endfunction

    function automatic logic [31:0] peek(input int k, input int sel);
        case (k)
            0:       return g_cfg[0].mon[sel];
            1:       return g_cfg[1].mon[sel];
            default: return g_cfg[2].mon[sel];
        endcase
    endfunction

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (!is_idle(k) && n < 20000) begin
            @(posedge clk);
            #2;
            n++;
        end
        // One more edge so the final accepted beat has updated the counter
        @(posedge clk);
        #2;
        if (n >= 20000) check_val($sformatf("c%0d drain timeout", k), 32'd1, 32'd0);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Single word, LSB first, full throughput
        push(0, 32'h44332211);
        wait_idle(0);
        check_val("c0 cnt one word", peek(0, 3), 32'd1);
        check_val("c0 pops one word", peek(0, 5), 32'd1);

        // Two words, MSB first, back-to-back
        push(1, 32'h44332211);
        push(1, 32'h88776655);
        wait_idle(1);
        check_val("c1 cnt two words", peek(1, 3), 32'd2);

        // One beat per word
        for (int i = 0; i < 10; i++) push(2, $urandom() & 32'hFF);
        wait_idle(2);
        check_val("c2 cnt ten words", peek(2, 3), 32'd10);
        check_val("c2 pops ten words", peek(2, 5), 32'd10);

        // 100 words with random backpressure
        g_cfg[0].ready_pct = 50;
        for (int i = 0; i < 100; i++) push(0, $urandom());
        wait_idle(0);
        check_val("c0 cnt after 100", peek(0, 3), 32'd101);

        // 4-bit counter wrap: 15, 16, 17 words total
        g_cfg[1].ready_pct = 60;
        for (int i = 0; i < 13; i++) push(1, $urandom());
        wait_idle(1);
        check_val("c1 cnt at 15", peek(1, 3), 32'd15);
        push(1, $urandom());
        wait_idle(1);
        check_val("c1 cnt at 16", peek(1, 3), 32'd0);
        push(1, $urandom());
        wait_idle(1);
        check_val("c1 cnt at 17", peek(1, 3), 32'd1);

        g_cfg[2].ready_pct = 40;
        for (int i = 0; i < 20; i++) push(2, $urandom() & 32'hFF);
        wait_idle(2);
        check_val("c2 cnt after 30", peek(2, 3), 32'd30);

        // Reset in the middle of a word
        g_cfg[0].ready_pct = 100;
        push(0, 32'hDDCCBBAA);
        push(0, 32'h12345678);
        t = 0;
        while (!(g_cfg[0].beats_q.size() == 2 && g_cfg[0].fifo_q.size() == 1) && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        check_val("c0 mid-word reach", 32'(t < 100), 32'd1);
        check_val("c0 mid-word data", peek(0, 1), 32'h000000CC);
        rst = 1'b1;
        #1;
        check_val("c0 async rst valid", peek(0, 0), 32'd0);
        check_val("c0 async rst data",  peek(0, 1), 32'd0);
        check_val("c0 async rst last",  peek(0, 2), 32'd0);
        check_val("c0 async rst cnt",   peek(0, 3), 32'd0);
        check_val("c0 async rst rd",    peek(0, 4), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_idle(0);
        check_val("c0 cnt after reset", peek(0, 3), 32'd1);
        check_val("c0 pops total", peek(0, 5), 32'd103);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
